// File: rtl/poci_serializer.sv
// poci_serializer
//   Controller-out (POCI) side of the SPI slave. When the PICO deserializer
//   flags a completed byte, the byte selected by the POCI mux is captured and
//   shifted out MSB-first on serial_out, one bit per sclk.
//
// Ports
//   sclk        SPI clock; all state updates on its rising edge
//   rstn        synchronous active-low reset
//   msg_flag    byte-complete flag from PICO (may be held high several cycles)
//   read_data   byte presented by the POCI mux
//   tx_en       readback enable, sampled at the msg_flag rising edge
//   serial_out  POCI serial data, MSB first
//   busy        high while a byte is being shifted
//   bit_cnt     index of the bit currently on serial_out (0 = MSB)
//   byte_done   one-cycle pulse after the last bit of a byte
//   overrun     sticky: a new byte was flagged before the current one finished
module poci_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             sclk,
    input  logic             rstn,
    input  logic             msg_flag,
    input  logic [WIDTH-1:0] read_data,
    input  logic             tx_en,
    output logic             serial_out,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             byte_done,
    output logic             overrun
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] shift_reg, shift_n;
    logic [CNT_W-1:0] cnt_n;
    logic             done_n;
    logic             ovr_n;
    logic             msg_flag_d;
    logic             load_ev;

    // One event per msg_flag rise, however long the flag is held.
    assign load_ev = msg_flag & ~msg_flag_d & tx_en;

    // shift_reg is cleared whenever the block goes idle, so its MSB is
    // already 0 outside SHIFT and no output gating is needed.
    assign serial_out = shift_reg[WIDTH-1];
    assign busy       = (state == SHIFT);

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            byte_done  <= 1'b0;
            overrun    <= 1'b0;
            msg_flag_d <= 1'b0;
        end else begin
            state      <= state_n;
            shift_reg  <= shift_n;
            bit_cnt    <= cnt_n;
            byte_done  <= done_n;
            overrun    <= ovr_n;
            msg_flag_d <= msg_flag;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        cnt_n   = bit_cnt;
        done_n  = 1'b0;
        ovr_n   = overrun;

        case (state)
            IDLE: begin
                if (load_ev) begin
                    shift_n = read_data;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end

            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    done_n = 1'b1;
                    if (load_ev) begin
                        // Back-to-back: reload without an idle gap.
                        shift_n = read_data;
                        cnt_n   = '0;
                    end else begin
                        shift_n = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end else begin
                    shift_n = {shift_reg[WIDTH-2:0], 1'b0};
                    cnt_n   = bit_cnt + CNT_W'(1);
                    // The colliding byte is dropped; the current one carries on.
                    if (load_ev) begin
                        ovr_n = 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_poci_serializer.sv
// tb_poci_serializer
//   Self-checking bench for poci_serializer. A queue-based reference model
//   holds the bits still to appear on serial_out; each test drives stimulus
//   and compares the DUT outputs against the model after every sclk edge.
module tb_poci_serializer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic             sclk = 1'b0;
    logic             rstn;
    logic             msg_flag;
    logic [WIDTH-1:0] read_data;
    logic             tx_en;
    logic             serial_out;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             byte_done;
    logic             overrun;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Reference model: queue of bits yet to be shown, front = bit on the line.
    bit m_q[$];
    bit m_prev = 1'b0;
    bit m_done = 1'b0;
    bit m_over = 1'b0;

    poci_serializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .sclk       (sclk),
        .rstn       (rstn),
        .msg_flag   (msg_flag),
        .read_data  (read_data),
        .tx_en      (tx_en),
        .serial_out (serial_out),
        .busy       (busy),
        .bit_cnt    (bit_cnt),
        .byte_done  (byte_done),
        .overrun    (overrun)
    );

    always #5 sclk = ~sclk;

    wire [6:0] dut_vec = {serial_out, busy, bit_cnt, byte_done, overrun};

    function automatic logic [6:0] exp_vec();
        logic             s;
        logic             b;
        logic [CNT_W-1:0] c;
        s = (m_q.size() > 0) ? m_q[0] : 1'b0;
        b = (m_q.size() > 0);
        c = (m_q.size() > 0) ? CNT_W'(WIDTH - m_q.size()) : '0;
        return {s, b, c, m_done, m_over};
    endfunction

    task automatic model_edge();
        bit rise;
        rise = msg_flag && !m_prev && tx_en;
        if (!rstn) begin
            m_q.delete();
            m_done = 1'b0;
            m_over = 1'b0;
            m_prev = 1'b0;
        end else begin
            m_done = (m_q.size() == 1);
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (rise) begin
                if (m_q.size() == 0) begin
                    for (int i = WIDTH - 1; i >= 0; i--) m_q.push_back(read_data[i]);
                end else begin
                    m_over = 1'b1;
                end
            end
            m_prev = msg_flag;
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; msg_flag = 1'b1; read_data = 8'hFF; tx_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL reset_model cyc %0d: got %b expected %b", cyc, dut_vec, exp_vec());
            end
            tests_run++;
            if (dut_vec !== 7'b0) begin
                tests_failed++;
                $display("FAIL reset_zero cyc %0d: got %b expected %b", cyc, dut_vec, 7'b0);
            end
        end
        msg_flag = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_single_byte();
        logic [WIDTH-1:0] cap = '0;
        int dones = 0;
        int busy_cycles = 0;
        msg_flag = 1'b0; tx_en = 1'b1;
        tick();
        msg_flag = 1'b1; read_data = 8'b1010_1010;
        for (int i = 0; i < 12; i++) begin
            tick();
            msg_flag = 1'b0;
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL single_byte cyc %0d: got %b expected %b", cyc, dut_vec, exp_vec());
            end
            if (busy) begin cap = {cap[WIDTH-2:0], serial_out}; busy_cycles++; end
            if (byte_done) dones++;
        end
        tests_run++;
        if (cap !== 8'hAA || busy_cycles != 8 || dones != 1) begin
            tests_failed++;
            $display("FAIL single_byte_summary: got bits %h busy %0d done %0d expected aa 8 1",
                     cap, busy_cycles, dones);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*WIDTH-1:0] cap = '0;
        int dones = 0;
        int busy_cycles = 0;
        msg_flag = 1'b1; read_data = 8'hC3;
        for (int i = 0; i < 8 + 1 + 10; i++) begin
            if (i == 3) msg_flag = 1'b0;
            if (i == 8) begin
                // One cycle before the last-bit edge: line shows the final bit.
                tests_run++;
                if (bit_cnt !== 3'd7) begin
                    tests_failed++;
                    $display("FAIL b2b_last_bit_cnt: got %0d expected 7", bit_cnt);
                end
                msg_flag = 1'b1; read_data = 8'h5A;
            end
            if (i == 9) msg_flag = 1'b0;
            tick();
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL back_to_back cyc %0d: got %b expected %b", cyc, dut_vec, exp_vec());
            end
            if (busy) begin cap = {cap[2*WIDTH-2:0], serial_out}; busy_cycles++; end
            if (byte_done) dones++;
        end
        tests_run++;
        if (cap !== 16'hC35A || busy_cycles != 16 || dones != 2) begin
            tests_failed++;
            $display("FAIL back_to_back_summary: got bits %h busy %0d done %0d expected c35a 16 2",
                     cap, busy_cycles, dones);
        end
    endtask

    task automatic test_overrun();
        logic [WIDTH-1:0] cap = '0;
        msg_flag = 1'b1; read_data = 8'hF0;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) msg_flag = 1'b0;
            if (i == 4) begin
                tests_run++;
                if (bit_cnt !== 3'd3) begin
                    tests_failed++;
                    $display("FAIL overrun_bit_cnt: got %0d expected 3", bit_cnt);
                end
                msg_flag = 1'b1; read_data = 8'h0F;
            end
            if (i == 5) msg_flag = 1'b0;
            tick();
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL overrun cyc %0d: got %b expected %b", cyc, dut_vec, exp_vec());
            end
            if (busy) cap = {cap[WIDTH-2:0], serial_out};
        end
        tests_run++;
        if (cap !== 8'hF0 || overrun !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_summary: got bits %h ovr %b busy %b expected f0 1 0",
                     cap, overrun, busy);
        end
    endtask

    task automatic test_disable_and_reset();
        int dones = 0;
        tx_en = 1'b0; msg_flag = 1'b1; read_data = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            msg_flag = 1'b0;
            tests_run++;
            if (dut_vec !== exp_vec() || busy !== 1'b0 || serial_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL tx_disabled cyc %0d: got %b expected %b", cyc, dut_vec, exp_vec());
            end
        end
        tx_en = 1'b1; msg_flag = 1'b1; read_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            tick();
            msg_flag = 1'b0;
        end
        tests_run++;
        if (bit_cnt !== 3'd4 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_byte_pre: got cnt %0d busy %b expected 4 1", bit_cnt, busy);
        end
        rstn = 1'b0;
        tick();
        tests_run++;
        if (dut_vec !== 7'b0 || dut_vec !== exp_vec()) begin
            tests_failed++;
            $display("FAIL mid_byte_reset: got %b expected %b", dut_vec, 7'b0);
        end
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (byte_done) dones++;
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                $display("FAIL post_reset cyc %0d: got %b expected %b", cyc, dut_vec, exp_vec());
            end
        end
        tests_run++;
        if (dones != 0) begin
            tests_failed++;
            $display("FAIL aborted_byte_done: got %0d pulses expected 0", dones);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 600; i++) begin
            rstn      = ($urandom_range(0, 99) >= 2);
            msg_flag  = ($urandom_range(0, 5) == 0) ? ~msg_flag : msg_flag;
            tx_en     = ($urandom_range(0, 9) >= 2);
            read_data = WIDTH'($urandom);
            tick();
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                tests_failed++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cyc %0d: got %b expected %b", cyc, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        rstn = 1'b0; msg_flag = 1'b0; read_data = '0; tx_en = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_disable_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
